// File: rtl/mult_sweep_if.sv
// Operand/product bus between the sweep checker and the multiplier under test.
interface mult_sweep_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0]   inA;
    logic [WIDTH-1:0]   inB;
    logic [2*WIDTH-1:0] Y;

    // Checker side: drives operands, receives the product.
    modport master (output inA, output inB, input Y);
    // Multiplier side: receives operands, drives the product.
    modport slave  (input inA, input inB, output Y);
endinterface

// File: rtl/mult_sweep_checker.sv
// Exhaustive operand sweep for a pipelined multiplier with on-chip error-distance scoring.
// Operands stream one pair per clock (A outer, B inner). Each issued pair travels down a
// LATENCY-deep tag line and is scored against Y on the edge it leaves the line.
module mult_sweep_checker #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ACC_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    mult_sweep_if.master         mul,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic [ACC_W-1:0]     sum_abs_ed,
    output logic [2*WIDTH-1:0]   max_abs_ed,
    output logic [WIDTH-1:0]     worst_a,
    output logic [WIDTH-1:0]     worst_b
);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [PW-1:0]    exact;
    } tag_t;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  ina_q, ina_d;
    logic [WIDTH-1:0]  inb_q, inb_d;
    tag_t              line_q [LATENCY];
    tag_t              line_d [LATENCY];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW:0]       err_q, err_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [PW-1:0]     max_q, max_d;
    logic [WIDTH-1:0]  wa_q, wa_d;
    logic [WIDTH-1:0]  wb_q, wb_d;

    tag_t              ret_c;
    logic              last_ret_c;
    logic              start_go_c;
    logic [PW-1:0]     ed_c;
    logic [ACC_W:0]    sum_wide_c;

    // Retiring tag, its absolute error distance and the saturating running sum.
    always_comb begin
        ret_c      = line_q[LATENCY-1];
        last_ret_c = ret_c.vld && (ret_c.a == '1) && (ret_c.b == '1);
        start_go_c = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
        ed_c       = (mul.Y >= ret_c.exact) ? (mul.Y - ret_c.exact) : (ret_c.exact - mul.Y);
        sum_wide_c = {1'b0, sum_q} + (ACC_W+1)'(ed_c);
    end

    // Next-state: sweep sequencing, tag line shift, statistics update.
    always_comb begin
        state_d = state_q;
        ina_d   = ina_q;
        inb_d   = inb_q;
        err_d   = err_q;
        sum_d   = sum_q;
        max_d   = max_q;
        wa_d    = wa_q;
        wb_d    = wb_q;

        line_d[0].vld   = (state_q == S_SWEEP);
        line_d[0].a     = ina_q;
        line_d[0].b     = inb_q;
        line_d[0].exact = PW'(ina_q) * PW'(inb_q);
        for (int i = 1; i < int'(LATENCY); i++) begin
            line_d[i] = line_q[i-1];
        end

        if (ret_c.vld && !abort) begin
            if (ed_c != '0) begin
                err_d = err_q + (PW+1)'(1);
            end
            sum_d = sum_wide_c[ACC_W] ? '1 : sum_wide_c[ACC_W-1:0];
            if (ed_c > max_q) begin
                max_d = ed_c;
                wa_d  = ret_c.a;
                wb_d  = ret_c.b;
            end
        end

        case (state_q)
            S_SWEEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if ({ina_q, inb_q} == '1) begin
                    state_d = S_DRAIN;
                end else begin
                    {ina_d, inb_d} = {ina_q, inb_q} + PW'(1);
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_ret_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start_go_c) begin
                    state_d = S_SWEEP;
                end
            end
            default: begin
                if (start_go_c) begin
                    state_d = S_SWEEP;
                end
            end
        endcase

        // Aborting drops operands to zero and discards every in-flight tag.
        if (abort && (state_q != S_IDLE)) begin
            ina_d = '0;
            inb_d = '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                line_d[i] = '0;
            end
        end

        // A honoured start restarts the sweep from pair 0 with clean statistics.
        if (start_go_c) begin
            ina_d = '0;
            inb_d = '0;
            err_d = '0;
            sum_d = '0;
            max_d = '0;
            wa_d  = '0;
            wb_d  = '0;
        end

        busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ina_q   <= '0;
            inb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ina_q   <= ina_d;
            inb_q   <= inb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            for (int i = 0; i < int'(LATENCY); i++) begin
                line_q[i] <= line_d[i];
            end
        end
    end

    assign mul.inA    = ina_q;
    assign mul.inB    = inb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_count  = err_q;
    assign sum_abs_ed = sum_q;
    assign max_abs_ed = max_q;
    assign worst_a    = wa_q;
    assign worst_b    = wb_q;
endmodule
